// File: rtl/m68k_bus_responder_if.sv
// 68000 bus signals seen by the responder: address, function code, strobes,
// direction, the sampled bus clock, and the HIT debug pulse.
interface m68k_bus_responder_if;
  logic        M68K_CLK;
  logic [23:1] M68K_A;
  logic [2:0]  M68K_FC;
  logic        M68K_AS_n;
  logic        M68K_UDS_n;
  logic        M68K_LDS_n;
  logic        M68K_RW;
  logic        HIT;

  modport master (
    output M68K_CLK, M68K_A, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW,
    input  HIT
  );

  modport slave (
    input  M68K_CLK, M68K_A, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW,
    output HIT
  );
endinterface

// File: rtl/m68k_bus_responder.sv
// 68000 bus slave: 8 x 16-bit register window, DTACK after WAIT_CLKS bus-clock falls.
// Define RESP_BERR_EN to answer reserved registers 6-7 with BERR instead of ignoring them.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR = 24'hE90000,
  parameter int unsigned WAIT_CLKS = 2,
  parameter logic [15:0] ID_VALUE  = 16'h5053
) (
  input  logic                       PI_CLK,
  input  logic                       RESET_n,
  m68k_bus_responder_if.slave        bus,
  inout  wire  [15:0]                M68K_D,
  output wire                        M68K_DTACK_n,
  output wire                        M68K_BERR_n
);

`ifdef RESP_BERR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_ACK, S_HOLD, S_IGNORE, S_BERR
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_ACK, S_HOLD, S_IGNORE
  } state_e;
`endif

  localparam logic [3:0] WAIT_LAST = (WAIT_CLKS == 0) ? 4'd0 : 4'(WAIT_CLKS - 1);

  // Two-flop synchronisers; the bus clock gets a third stage for edge detection.
  logic [1:0] as_sync_q, uds_sync_q, lds_sync_q;
  logic [2:0] clk_sync_q;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        rw_q, rw_d, uds_q, uds_d, lds_q, lds_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] scratch_q [4];
  logic [15:0] scratch_d [4];
  logic        dtack_q, dtack_d, d_oe_q, d_oe_d, hit_q, hit_d;
`ifdef RESP_BERR_EN
  logic        berr_q, berr_d;
`endif

  logic       as_low, ds_low, m_fall, addr_hit, reserved;
  logic [1:0] wr_slot, rd_slot;

  assign as_low   = ~as_sync_q[1];
  assign ds_low   = ~uds_sync_q[1] | ~lds_sync_q[1];
  assign m_fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign addr_hit = (bus.M68K_A[23:4] == BASE_ADDR[23:4]) && (bus.M68K_FC != 3'b111);
  assign reserved = (bus.M68K_A[3:2] == 2'b11);
  assign wr_slot  = 2'(idx_q - 3'd2);
  assign rd_slot  = 2'(idx_d - 3'd2);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    rw_d       = rw_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    rd_data_d  = rd_data_q;
    cnt_d      = cnt_q;
    scratch_d  = scratch_q;

    case (state_q)
      S_IDLE: if (as_low && ds_low) state_d = S_DECODE;
      S_DECODE: begin
        idx_d      = bus.M68K_A[3:1];
        rw_d       = bus.M68K_RW;
        uds_d      = ~uds_sync_q[1];
        lds_d      = ~lds_sync_q[1];
        wait_cnt_d = '0;
        if (!addr_hit)            state_d = S_IGNORE;
`ifdef RESP_BERR_EN
        else if (reserved)        state_d = S_BERR;
`else
        else if (reserved)        state_d = S_IGNORE;
`endif
        else if (WAIT_CLKS == 0)  state_d = S_ACK;
        else                      state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!as_low) state_d = S_IDLE;
        else if (m_fall) begin
          if (wait_cnt_q == WAIT_LAST) state_d = S_ACK;
          else                         wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_ACK: begin
        // ACK lasts exactly one cycle, so the write and the count happen once per access.
        if (!rw_q && (idx_q inside {[3'd2:3'd5]})) begin
          if (uds_q) scratch_d[wr_slot][15:8] = M68K_D[15:8];
          if (lds_q) scratch_d[wr_slot][7:0]  = M68K_D[7:0];
        end
        cnt_d   = cnt_q + 16'd1;
        state_d = S_HOLD;
      end
      S_HOLD, S_IGNORE: if (!as_low) state_d = S_IDLE;
`ifdef RESP_BERR_EN
      S_BERR:           if (!as_low) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    // Read data is captured on ACK entry; register 1 returns the pre-increment count.
    if (state_d == S_ACK && state_q != S_ACK) begin
      case (idx_d)
        3'd0:                      rd_data_d = ID_VALUE;
        3'd1:                      rd_data_d = cnt_q;
        3'd2, 3'd3, 3'd4, 3'd5:    rd_data_d = scratch_q[rd_slot];
        default:                   rd_data_d = '0;
      endcase
    end

    dtack_d = (state_d == S_ACK) || (state_d == S_HOLD);
    d_oe_d  = dtack_d && rw_d;
    hit_d   = (state_d == S_ACK);
`ifdef RESP_BERR_EN
    berr_d  = (state_d == S_BERR);
`endif
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      as_sync_q  <= '1;
      uds_sync_q <= '1;
      lds_sync_q <= '1;
      clk_sync_q <= '0;
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      rw_q       <= 1'b1;
      uds_q      <= 1'b0;
      lds_q      <= 1'b0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      // NOTE: the scratch array is tiny and must read 0 after reset, so it is reset like any flop.
      scratch_q  <= '{default: '0};
      dtack_q    <= 1'b0;
      d_oe_q     <= 1'b0;
      hit_q      <= 1'b0;
`ifdef RESP_BERR_EN
      berr_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      as_sync_q  <= {as_sync_q[0], bus.M68K_AS_n};
      uds_sync_q <= {uds_sync_q[0], bus.M68K_UDS_n};
      lds_sync_q <= {lds_sync_q[0], bus.M68K_LDS_n};
      clk_sync_q <= {clk_sync_q[1:0], bus.M68K_CLK};
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      rw_q       <= rw_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
      scratch_q  <= scratch_d;
      dtack_q    <= dtack_d;
      d_oe_q     <= d_oe_d;
      hit_q      <= hit_d;
`ifdef RESP_BERR_EN
      berr_q     <= berr_d;
`endif
    end
  end

  assign M68K_DTACK_n = dtack_q ? 1'b0 : 1'bz;
  assign M68K_D       = d_oe_q ? rd_data_q : 16'bz;
`ifdef RESP_BERR_EN
  assign M68K_BERR_n  = berr_q ? 1'b0 : 1'bz;
`else
  assign M68K_BERR_n  = 1'bz;
`endif
  assign bus.HIT      = hit_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Self-checking bench for m68k_bus_responder: directed scenarios plus randomized
// accesses compared against a register-level reference model.
module tb_m68k_bus_responder;
  localparam logic [23:0] BASE = 24'hE90000;
  localparam int          WAIT = 2;
  localparam logic [15:0] ID   = 16'h5053;

  logic pi_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 pi_clk = ~pi_clk;

  m68k_bus_responder_if bus ();
  wire  [15:0] m68k_d;
  wire         dtack_n, berr_n;
  logic        tb_d_oe  = 1'b0;
  logic [15:0] tb_d_val = '0;

  assign m68k_d = tb_d_oe ? tb_d_val : 16'bz;
  pullup (dtack_n);
  pullup (berr_n);
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (m68k_d[i]);
  end

  m68k_bus_responder dut (
    .PI_CLK       (pi_clk),
    .RESET_n      (rst_n),
    .bus          (bus),
    .M68K_D       (m68k_d),
    .M68K_DTACK_n (dtack_n),
    .M68K_BERR_n  (berr_n)
  );

  initial begin
    bus.M68K_CLK = 1'b0;
    #2;
    forever #35 bus.M68K_CLK = ~bus.M68K_CLK;
  end

  int fall_cnt = 0, hit_cnt = 0;
  always @(negedge bus.M68K_CLK) fall_cnt++;
  always @(negedge pi_clk) if (bus.HIT === 1'b1) hit_cnt++;

  int errors = 0, checks = 0;

  // Reference model: the register file as the bus master sees it.
  typedef enum {R_ACK, R_IGNORE, R_BERR} resp_e;
  logic [15:0] m_scr [4];
  logic [15:0] m_cnt;

  function automatic resp_e expect_resp(input logic [23:0] addr, input logic [2:0] fc);
    if (addr[23:4] != BASE[23:4] || fc == 3'd7) return R_IGNORE;
`ifdef RESP_BERR_EN
    if (addr[3:1] >= 3'd6) return R_BERR;
`else
    if (addr[3:1] >= 3'd6) return R_IGNORE;
`endif
    return R_ACK;
  endfunction

  function automatic logic [15:0] model_read(input int idx);
    if (idx == 0) return ID;
    if (idx == 1) return m_cnt;
    if (idx >= 2 && idx <= 5) return m_scr[idx-2];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_scr[i] = 16'h0000;
    m_cnt = 16'h0000;
  endtask

  task automatic model_commit(input int idx, input bit rw, input bit uds, input bit lds,
                              input logic [15:0] wdata);
    if (!rw && idx >= 2 && idx <= 5) begin
      if (uds) m_scr[idx-2][15:8] = wdata[15:8];
      if (lds) m_scr[idx-2][7:0]  = wdata[7:0];
    end
    m_cnt = m_cnt + 16'd1;
  endtask

  typedef struct {
    bit          dtack;
    bit          berr;
    bit          drove;
    bit          released;
    logic [15:0] rdata;
    int          falls;
    int          hits;
  } obs_t;

  // One complete bus cycle; AS is asserted just after a bus-clock rise so the
  // number of bus-clock falls before DTACK is exact.
  task automatic access(input logic [23:0] addr, input logic [2:0] fc, input bit rw,
                        input bit uds, input bit lds, input logic [15:0] wdata,
                        output obs_t o);
    int f0, h0;
    o.dtack = 0; o.berr = 0; o.drove = 0; o.released = 0;
    o.rdata = 16'h0000; o.falls = -1; o.hits = 0;
    @(posedge bus.M68K_CLK);
    @(negedge pi_clk);
    bus.M68K_A  = addr[23:1];
    bus.M68K_FC = fc;
    bus.M68K_RW = rw;
    tb_d_val    = wdata;
    tb_d_oe     = !rw;
    bus.M68K_AS_n  = 1'b0;
    bus.M68K_UDS_n = !uds;
    bus.M68K_LDS_n = !lds;
    f0 = fall_cnt;
    h0 = hit_cnt;
    for (int i = 0; i < 80; i++) begin
      @(posedge pi_clk);
      #1;
      if (rw && dtack_n !== 1'b0 && m68k_d !== 16'hFFFF) o.drove = 1;
      if (dtack_n === 1'b0) begin
        o.dtack = 1; o.rdata = m68k_d; o.falls = fall_cnt - f0;
        break;
      end
      if (berr_n === 1'b0) begin
        o.berr = 1;
        break;
      end
    end
    repeat (2) @(posedge pi_clk);
    @(negedge pi_clk);
    bus.M68K_AS_n = 1'b1; bus.M68K_UDS_n = 1'b1; bus.M68K_LDS_n = 1'b1;
    tb_d_oe = 1'b0;
    repeat (3) @(posedge pi_clk);
    #1;
    o.released = (dtack_n === 1'b1) && (berr_n === 1'b1) && (m68k_d === 16'hFFFF);
    @(negedge pi_clk);
    o.hits = hit_cnt - h0;
    if (expect_resp(addr, fc) == R_ACK) model_commit(int'(addr[3:1]), rw, uds, lds, wdata);
  endtask

  task automatic test_reset();
    obs_t o;
    logic [15:0] exp;
    bus.M68K_AS_n = 1'b1; bus.M68K_UDS_n = 1'b1; bus.M68K_LDS_n = 1'b1;
    bus.M68K_RW = 1'b1; bus.M68K_FC = 3'd5; bus.M68K_A = '0;
    model_reset();
    repeat (3) @(posedge pi_clk);
    #1;
    checks++;
    if (dtack_n !== 1'b1 || berr_n !== 1'b1 || m68k_d !== 16'hFFFF || bus.HIT !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dtack_n=%b berr_n=%b d=%h hit=%b, want 1 1 ffff 0",
               dtack_n, berr_n, m68k_d, bus.HIT);
    end
    @(negedge pi_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge pi_clk);
    exp = model_read(2);
    access(BASE + 24'h4, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (!o.dtack || o.rdata !== exp) begin
      errors++;
      $display("FAIL reset_reg2: dtack=%0d data=%h, want 1 %h", o.dtack, o.rdata, exp);
    end
  endtask

  task automatic test_id_read();
    obs_t o;
    logic [15:0] exp_cnt;
    exp_cnt = m_cnt;
    access(BASE, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (!o.dtack || o.rdata !== ID) begin
      errors++;
      $display("FAIL id_read: dtack=%0d data=%h, want 1 %h", o.dtack, o.rdata, ID);
    end
    checks++;
    if (o.falls != WAIT) begin
      errors++;
      $display("FAIL id_wait_falls: got %0d bus-clock falls before DTACK, want %0d", o.falls, WAIT);
    end
    checks++;
    if (o.hits != 1 || !o.released) begin
      errors++;
      $display("FAIL id_hit_release: hits=%0d released=%0d, want 1 1", o.hits, o.released);
    end
    access(BASE + 24'h2, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp_cnt + 16'd1) begin
      errors++;
      $display("FAIL counter_after_id: got %h want %h", o.rdata, exp_cnt + 16'd1);
    end
  endtask

  task automatic test_byte_lanes();
    obs_t o;
    access(BASE + 24'h4, 3'd5, 1'b0, 1'b1, 1'b0, 16'hA5C3, o);
    access(BASE + 24'h4, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== 16'hA500) begin
      errors++;
      $display("FAIL uds_write: got %h want a500", o.rdata);
    end
    access(BASE + 24'h4, 3'd5, 1'b0, 1'b0, 1'b1, 16'h003C, o);
    access(BASE + 24'h4, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== 16'hA53C) begin
      errors++;
      $display("FAIL lds_write: got %h want a53c", o.rdata);
    end
  endtask

  task automatic test_no_match();
    obs_t o;
    access(24'hE80000, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.dtack || o.berr || o.drove || !o.released || o.hits != 0) begin
      errors++;
      $display("FAIL addr_miss: dtack=%0d berr=%0d drove=%0d hits=%0d, want all 0",
               o.dtack, o.berr, o.drove, o.hits);
    end
    access(BASE, 3'd7, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.dtack || o.berr || o.drove || !o.released || o.hits != 0) begin
      errors++;
      $display("FAIL fc7_miss: dtack=%0d berr=%0d drove=%0d hits=%0d, want all 0",
               o.dtack, o.berr, o.drove, o.hits);
    end
  endtask

  task automatic test_reserved();
    obs_t o;
    logic [15:0] exp_cnt;
    bit exp_berr;
`ifdef RESP_BERR_EN
    exp_berr = 1;
`else
    exp_berr = 0;
`endif
    exp_cnt = m_cnt;
    access(BASE + 24'hC, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.dtack || o.berr != exp_berr || o.drove || !o.released || o.hits != 0) begin
      errors++;
      $display("FAIL reserved_reg6: dtack=%0d berr=%0d drove=%0d hits=%0d, want 0 %0d 0 0",
               o.dtack, o.berr, o.drove, o.hits, exp_berr);
    end
    access(BASE + 24'h2, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp_cnt) begin
      errors++;
      $display("FAIL reserved_no_count: got %h want %h", o.rdata, exp_cnt);
    end
  endtask

  task automatic test_readonly_regs();
    obs_t o;
    logic [15:0] exp_cnt;
    exp_cnt = m_cnt + 16'd1;
    access(BASE + 24'h2, 3'd5, 1'b0, 1'b1, 1'b1, 16'hFFFF, o);
    access(BASE + 24'h2, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp_cnt) begin
      errors++;
      $display("FAIL reg1_write: got %h want %h", o.rdata, exp_cnt);
    end
    access(BASE, 3'd5, 1'b0, 1'b1, 1'b1, 16'h1234, o);
    access(BASE, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== ID) begin
      errors++;
      $display("FAIL reg0_write: got %h want %h", o.rdata, ID);
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  idx, fc;
      logic [1:0]  lanes;
      logic [23:0] addr;
      logic [15:0] wdata, exp_d;
      bit          rw;
      resp_e       exp;
      idx   = 3'($urandom_range(0, 7));
      fc    = 3'($urandom_range(0, 7));
      lanes = 2'($urandom_range(1, 3));
      rw    = 1'($urandom_range(0, 1));
      wdata = 16'($urandom);
      if ($urandom_range(0, 9) != 0) addr = {BASE[23:4], idx, 1'b0};
      else addr = {BASE[23:4] ^ 20'($urandom_range(1, 20'hFFFFF)), idx, 1'b0};
      exp   = expect_resp(addr, fc);
      exp_d = model_read(int'(idx));
      access(addr, fc, rw, lanes[1], lanes[0], wdata, o);
      checks++;
      if (o.dtack != (exp == R_ACK) || o.berr != (exp == R_BERR) || o.drove ||
          !o.released || o.hits != ((exp == R_ACK) ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_resp[%0d] a=%h fc=%0d: dtack=%0d berr=%0d drove=%0d rel=%0d hits=%0d, want resp %s",
                 n, addr, fc, o.dtack, o.berr, o.drove, o.released, o.hits, exp.name());
      end
      if (rw && exp == R_ACK) begin
        checks++;
        if (o.rdata !== exp_d) begin
          errors++;
          $display("FAIL rand_read[%0d] idx=%0d: got %h want %h", n, idx, o.rdata, exp_d);
        end
      end
    end
  endtask

  task automatic test_abort();
    obs_t o;
    bit   seen;
    logic [15:0] exp_r2, exp_cnt;
    exp_r2  = m_scr[0];
    exp_cnt = m_cnt;
    seen    = 0;
    @(posedge bus.M68K_CLK);
    @(negedge pi_clk);
    bus.M68K_A = BASE[23:1] + 23'd2; bus.M68K_FC = 3'd5; bus.M68K_RW = 1'b0;
    tb_d_val = ~exp_r2; tb_d_oe = 1'b1;
    bus.M68K_AS_n = 1'b0; bus.M68K_UDS_n = 1'b0; bus.M68K_LDS_n = 1'b0;
    repeat (5) @(posedge pi_clk);
    @(negedge pi_clk);
    bus.M68K_AS_n = 1'b1; bus.M68K_UDS_n = 1'b1; bus.M68K_LDS_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge pi_clk);
      #1;
      if (dtack_n === 1'b0) seen = 1;
    end
    tb_d_oe = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_dtack: DTACK asserted after AS negated in wait, want none");
    end
    access(BASE + 24'h4, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp_r2) begin
      errors++;
      $display("FAIL abort_reg2: got %h want %h", o.rdata, exp_r2);
    end
    access(BASE + 24'h2, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp_cnt + 16'd1) begin
      errors++;
      $display("FAIL abort_count: got %h want %h", o.rdata, exp_cnt + 16'd1);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   seen;
    logic [15:0] exp;
    seen = 0;
    @(posedge bus.M68K_CLK);
    @(negedge pi_clk);
    bus.M68K_A = BASE[23:1] + 23'd2; bus.M68K_FC = 3'd5; bus.M68K_RW = 1'b0;
    tb_d_val = 16'hBEEF; tb_d_oe = 1'b1;
    bus.M68K_AS_n = 1'b0; bus.M68K_UDS_n = 1'b0; bus.M68K_LDS_n = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge pi_clk);
      #1;
      if (dtack_n === 1'b0) seen = 1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || dtack_n !== 1'b1 || bus.HIT !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ack: reached_ack=%0d dtack_n=%b hit=%b, want 1 1 0",
               seen, dtack_n, bus.HIT);
    end
    @(negedge pi_clk);
    bus.M68K_AS_n = 1'b1; bus.M68K_UDS_n = 1'b1; bus.M68K_LDS_n = 1'b1;
    tb_d_oe = 1'b0;
    repeat (3) @(negedge pi_clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge pi_clk);
    exp = model_read(2);
    access(BASE + 24'h4, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp) begin
      errors++;
      $display("FAIL reset_lost_write: got %h want %h", o.rdata, exp);
    end
    exp = model_read(1);
    access(BASE + 24'h2, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0, o);
    checks++;
    if (o.rdata !== exp) begin
      errors++;
      $display("FAIL reset_counter: got %h want %h", o.rdata, exp);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_id_read();
    test_byte_lanes();
    test_no_match();
    test_reserved();
    test_readonly_regs();
    test_random();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
